// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the register-file write port between A and B
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   freeze          blocks new grants while high
//   req/addr/data_a requester A (ALU/load writeback)
//   req/addr/data_b requester B (mult/div writeback)
//   ack_a, ack_b    one-cycle retire pulses
//   reg_write, write_register, write_data  register-file write port
//   last_grant      0 = A granted most recently, 1 = B
module regfile_write_arbiter #(
   parameter int N      = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              freeze,
   input  logic              req_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [N-1:0]      data_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [N-1:0]      data_b,
   output logic              ack_a,
   output logic              ack_b,
   output logic              reg_write,
   output logic [ADDR_W-1:0] write_register,
   output logic [N-1:0]      write_data,
   output logic              last_grant
);
   typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_t;
   state_t state;
   logic elig_a, elig_b, grant_a, grant_b;
   assign ack_a = state == WR_A;
   assign ack_b = state == WR_B;
   // a requester still showing req during its ack cycle is not re-granted
   always_comb begin
      elig_a  = req_a & ~freeze & ~ack_a;
      elig_b  = req_b & ~freeze & ~ack_b;
      grant_a = elig_a & (~elig_b | last_grant);
      grant_b = elig_b & ~grant_a;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         reg_write      <= 1'b0;
         write_register <= '0;
         write_data     <= '0;
         last_grant     <= 1'b1;
      end else begin
         state     <= grant_a ? WR_A : grant_b ? WR_B : IDLE;
         // writes to register 0 are acked but suppressed
         reg_write <= grant_a ? |addr_a : grant_b & |addr_b;
         if (grant_a | grant_b) begin
            write_register <= grant_a ? addr_a : addr_b;
            write_data     <= grant_a ? data_a : data_b;
            last_grant     <= grant_b;
         end
      end
   end
endmodule
